// File: rtl/rf_write_arbiter_if.sv
// Requester-side and RF-side signal bundle for rf_write_arbiter.
// lock_mask/wr_err exist only when RF_ARB_LOCK_EN is defined.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 2
`endif
`ifndef RF_DATA_WIDTH
`define RF_DATA_WIDTH 16
`endif

interface rf_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = `RF_ADDR_WIDTH,
    parameter int unsigned DATA_W  = `RF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*2-1:0]      req_len;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [ADDR_W-1:0]         rf_addr;
    logic                      rf_wren;
    logic [DATA_W-1:0]         rf_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
`ifdef RF_ARB_LOCK_EN
    logic [2**ADDR_W-1:0]      lock_mask;
    logic                      wr_err;

    modport master (
        output req_valid, req_addr, req_len, req_data, lock_mask,
        input  req_ready, rf_addr, rf_wren, rf_data, grant, busy, wr_err
    );
    modport slave (
        input  req_valid, req_addr, req_len, req_data, lock_mask,
        output req_ready, rf_addr, rf_wren, rf_data, grant, busy, wr_err
    );
`else
    modport master (
        output req_valid, req_addr, req_len, req_data,
        input  req_ready, rf_addr, rf_wren, rf_data, grant, busy
    );
    modport slave (
        input  req_valid, req_addr, req_len, req_data,
        output req_ready, rf_addr, rf_wren, rf_data, grant, busy
    );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ burst requesters.
// Optional write-lock checking is enabled by defining RF_ARB_LOCK_EN.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 2
`endif
`ifndef RF_DATA_WIDTH
`define RF_DATA_WIDTH 16
`endif

module rf_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = `RF_ADDR_WIDTH,
    parameter int unsigned DATA_W  = `RF_DATA_WIDTH
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [1:0]        beats_q, beats_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              rf_wren_q, rf_wren_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    int unsigned       idx;
    logic              accept;
    logic              write_ok;

    // Scan from the requester after the last owner, wrapping once around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign accept = (state_q == StBurst) && bus.req_valid[owner_q];

`ifdef RF_ARB_LOCK_EN
    logic wr_err_q, wr_err_d;
    logic locked;

    assign locked   = bus.lock_mask[cur_addr_q];
    assign write_ok = accept && !locked;
    assign wr_err_d = accept && locked;
    assign bus.wr_err = wr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
`else
    assign write_ok = accept;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cur_addr_d = cur_addr_q;
        beats_d    = beats_q;
        rf_wren_d  = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d    = pick;
                    cur_addr_d = bus.req_addr[pick*ADDR_W +: ADDR_W];
                    beats_d    = bus.req_len[pick*2 +: 2];
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    beats_d    = beats_q - 2'd1;
                    if (beats_q == 2'd0) begin
                        state_d = StIdle;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A locked beat is consumed but leaves the RF port untouched.
        if (write_ok) begin
            rf_wren_d = 1'b1;
            rf_addr_d = cur_addr_q;
            rf_data_d = bus.req_data[owner_q*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            cur_addr_q <= '0;
            beats_q    <= '0;
            rf_addr_q  <= '0;
            rf_wren_q  <= 1'b0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cur_addr_q <= cur_addr_d;
            beats_q    <= beats_d;
            rf_addr_q  <= rf_addr_d;
            rf_wren_q  <= rf_wren_d;
            rf_data_q  <= rf_data_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.grant     = '0;
        if (state_q == StBurst) begin
            bus.req_ready[owner_q] = 1'b1;
            bus.grant[owner_q]     = 1'b1;
        end
    end

    assign bus.busy    = (state_q == StBurst);
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_wren = rf_wren_q;
    assign bus.rf_data = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter; lock checks included when RF_ARB_LOCK_EN is defined.
// Requester bursts are bench-owned descriptors; a transaction-level model decides who is served.
module tb_rf_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 16;
    localparam int NREG    = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total  = 0;
    int bad    = 0;
    int cycle  = 0;
    bit gen_en = 1'b0;

    // Per-requester burst descriptors
    bit                has_burst [NUM_REQ];
    bit                granted   [NUM_REQ];
    int                b_addr    [NUM_REQ];
    int                b_len     [NUM_REQ];
    int                b_beat    [NUM_REQ];
    logic [DATA_W-1:0] b_data    [NUM_REQ][4];

    // Reference model state
    int                m_owner = -1;
    int                m_last  = NUM_REQ - 1;
    int                m_addr  = 0;
    int                m_left  = 0;
    int                hold_addr = 0;
    logic [DATA_W-1:0] hold_data = '0;

    typedef struct {
        int                stamp;
        int                addr;
        logic [DATA_W-1:0] data;
        bit                err;
    } wr_t;
    wr_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, act, exp);
        end
    endtask

    // Model: served requester and beat order follow directly from the round-robin rule.
    always @(posedge clk) begin
        wr_t e;
        cycle++;
        if (reset) begin
            if (m_owner >= 0) has_burst[m_owner] = 1'b0;
            m_owner   = -1;
            m_last    = NUM_REQ - 1;
            hold_addr = 0;
            hold_data = '0;
            sb.delete();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int r;
                r = (m_last + k) % NUM_REQ;
                if (bus.req_valid[r]) begin
                    m_owner    = r;
                    m_addr     = b_addr[r];
                    m_left     = b_len[r];
                    granted[r] = 1'b1;
                    break;
                end
            end
        end else if (bus.req_valid[m_owner]) begin
            e.stamp = cycle;
            e.addr  = m_addr;
            e.data  = b_data[m_owner][b_beat[m_owner]];
`ifdef RF_ARB_LOCK_EN
            e.err   = bus.lock_mask[m_addr];
`else
            e.err   = 1'b0;
`endif
            sb.push_back(e);
            b_beat[m_owner]++;
            m_addr = (m_addr + 1) % NREG;
            if (m_left == 0) begin
                has_burst[m_owner] = 1'b0;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_left--;
            end
        end
    end

    // Monitor first, then drive the next cycle's stimulus.
    always @(negedge clk) begin
        wr_t  e;
        logic present;
        logic err_out;
        logic [NUM_REQ-1:0] exp_oh;
`ifdef RF_ARB_LOCK_EN
        err_out = bus.wr_err;
`else
        err_out = 1'b0;
`endif
        present = bus.rf_wren | err_out;
        if (present) begin
            if (sb.size() == 0 || sb[0].stamp != cycle) begin
                check("unexpected_write", {31'd0, present}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rf_wren", {31'd0, bus.rf_wren}, {31'd0, !e.err});
                check("wr_err", {31'd0, err_out}, {31'd0, e.err});
                if (!e.err) begin
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end
        end else if (sb.size() != 0 && sb[0].stamp == cycle) begin
            e = sb.pop_front();
            check("missing_write", 32'd0, 32'd1);
        end
        check("rf_addr", 32'(bus.rf_addr), 32'(hold_addr));
        check("rf_data", 32'(bus.rf_data), 32'(hold_data));
        exp_oh = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
        check("grant", 32'(bus.grant), 32'(exp_oh));
        check("req_ready", 32'(bus.req_ready), 32'(exp_oh));
        check("busy", {31'd0, bus.busy}, {31'd0, m_owner >= 0});

        reset = (cycle < 3) || (gen_en && $urandom_range(0, 249) == 0);
`ifdef RF_ARB_LOCK_EN
        bus.lock_mask = gen_en ? NREG'($urandom) : '0;
`endif
        for (int r = 0; r < NUM_REQ; r++) begin
            bit stall;
            if (gen_en && !has_burst[r] && $urandom_range(0, 3) == 0) begin
                has_burst[r] = 1'b1;
                granted[r]   = 1'b0;
                b_addr[r]    = $urandom_range(0, NREG - 1);
                b_len[r]     = $urandom_range(0, 3);
                b_beat[r]    = 0;
                for (int k = 0; k < 4; k++) b_data[r][k] = DATA_W'($urandom);
            end
            stall = gen_en && $urandom_range(0, 4) == 0;
            bus.req_valid[r] = has_burst[r] && !stall;
            // Lanes carry junk once granted: the arbiter must ignore them mid-burst.
            if (has_burst[r] && !granted[r]) begin
                bus.req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(b_addr[r]);
                bus.req_len[r*2 +: 2]            = 2'(b_len[r]);
            end else begin
                bus.req_addr[r*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                bus.req_len[r*2 +: 2]            = 2'($urandom);
            end
            bus.req_data[r*DATA_W +: DATA_W] =
                has_burst[r] ? b_data[r][b_beat[r]] : DATA_W'($urandom);
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_data  = '0;
`ifdef RF_ARB_LOCK_EN
        bus.lock_mask = '0;
`endif
        // Directed opening: single beat to addr 2, then a wrapping 4-beat burst from addr 3.
        has_burst[0] = 1'b1; b_addr[0] = 2; b_len[0] = 0; b_beat[0] = 0;
        b_data[0][0] = 16'hABCD;
        has_burst[1] = 1'b1; b_addr[1] = 3; b_len[1] = 3; b_beat[1] = 0;
        b_data[1][0] = 16'd1; b_data[1][1] = 16'd2; b_data[1][2] = 16'd3; b_data[1][3] = 16'd4;
        repeat (40) @(posedge clk);
        gen_en = 1'b1;
        repeat (4000) @(posedge clk);
        gen_en = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        check("drain_idle", {31'd0, bus.busy}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
